// File: rtl/reg_dbg_display.sv
// reg_dbg_display
//   Drives the core's debug register select, waits for the combinational
//   register_value readback to settle, latches it, and shows the latched
//   16-bit value as four hex digits on a multiplexed active-low 7-segment
//   display.
//
// Optional feature macro: REG_DBG_AUTO_SCAN_EN
//   When defined, a free-running counter advances select every AUTO_PERIOD
//   cycles in addition to the push-button.
//
// Ports
//   clk            in   system clock
//   resetn         in   asynchronous active-low reset
//   btn_next       in   asynchronous push-button, rising edge advances select
//   register_value in   16-bit readback for the current select
//   select         out  5-bit register index to the core
//   seg            out  segments {g,f,e,d,c,b,a}, active-low
//   dp             out  decimal point, active-low
//   an             out  digit enables, active-low, an[0] = least significant nibble
//   value_valid    out  high while the displayed value matches select
module reg_dbg_display #(
  parameter int REFRESH_DIV   = 50000,
  parameter int SETTLE_CYCLES = 2
`ifdef REG_DBG_AUTO_SCAN_EN
  ,
  parameter int AUTO_PERIOD   = 100000000
`endif
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        btn_next,
  input  logic [15:0] register_value,
  output logic [4:0]  select,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        value_valid
);

  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {ST_SETTLE, ST_CAPTURE, ST_SHOW} state_e;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic             sync1_q, sync2_q, btn_prev_q, btn_pulse_q;
  logic             advance;
  state_e           state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [4:0]       select_q, select_d;
  logic [15:0]      value_q, value_d;
  logic             valid_q, valid_d;
  logic [REF_W-1:0] refresh_q, refresh_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       nibble;

  // Button: two-flop synchronizer, then a registered rising-edge detector.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      btn_prev_q  <= 1'b0;
      btn_pulse_q <= 1'b0;
    end else begin
      sync1_q     <= btn_next;
      sync2_q     <= sync1_q;
      btn_prev_q  <= sync2_q;
      btn_pulse_q <= sync2_q & ~btn_prev_q;
    end
  end

`ifdef REG_DBG_AUTO_SCAN_EN
  localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

  logic [AUTO_W-1:0] auto_q, auto_d;
  logic              auto_tick;

  // The auto timer restarts on every advance so a button press re-phases it;
  // a coincident tick and press still yield a single advance.
  always_comb begin
    auto_tick = (auto_q == AUTO_LAST);
    auto_d    = (btn_pulse_q || auto_tick) ? '0 : auto_q + 1'b1;
    advance   = btn_pulse_q | auto_tick;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) auto_q <= '0;
    else         auto_q <= auto_d;
  end
`else
  assign advance = btn_pulse_q;
`endif

  // Capture FSM: an advance wins over every state and restarts settling.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    select_d = select_q;
    value_d  = value_q;
    valid_d  = valid_q;
    if (advance) begin
      select_d = select_q + 5'd1;
      settle_d = '0;
      valid_d  = 1'b0;
      state_d  = ST_SETTLE;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          valid_d = 1'b0;
          if (settle_q == SET_LAST) state_d = ST_CAPTURE;
          else                      settle_d = settle_q + 1'b1;
        end
        ST_CAPTURE: begin
          value_d = register_value;
          valid_d = 1'b1;
          state_d = ST_SHOW;
        end
        ST_SHOW: ;
        default: state_d = ST_SETTLE;
      endcase
    end
  end

  // Display scan. Outputs are built from next-state values so an, seg and dp
  // always describe the same digit and the same latched value.
  always_comb begin
    if (refresh_q == REF_LAST) begin
      refresh_d = '0;
      idx_d     = idx_q + 2'd1;
    end else begin
      refresh_d = refresh_q + 1'b1;
      idx_d     = idx_q;
    end
    case (idx_d)
      2'd0:    nibble = value_d[3:0];
      2'd1:    nibble = value_d[7:4];
      2'd2:    nibble = value_d[11:8];
      default: nibble = value_d[15:12];
    endcase
    an_d  = ~(4'b0001 << idx_d);
    seg_d = hex7(nibble);
    dp_d  = ~((idx_d == 2'd0) && !valid_d);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_SETTLE;
      settle_q  <= '0;
      select_q  <= 5'd0;
      value_q   <= 16'h0000;
      valid_q   <= 1'b0;
      refresh_q <= '0;
      idx_q     <= 2'd0;
      an_q      <= 4'b1111;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      select_q  <= select_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign select      = select_q;
  assign value_valid = valid_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;

endmodule
